mat_vec_loader: RTL

Write-side sequencer for the 8x8 matrix-vector MAC array. It accepts a byte stream over a valid/ready handshake and steers each byte into the correct A-row FIFO or the B-vector FIFO. After a fixed compute window it snapshots the 8 MAC accumulators and returns them one at a time over a second valid/ready handshake. It sits between the host/memory byte source and the array's FIFO write ports and `Clr` input.

---
 rtl/mat_vec_loader.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/mat_vec_loader.sv
// mat_vec_loader: steers a byte stream into the MAC array's A-row/B FIFOs, then drains the accumulators.
// Optional feature macro MVL_ABORT_EN adds an abort input that cancels a job from any busy state.
module mat_vec_loader #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned COMPUTE_CYCLES = 24
) (
  input  logic                          clk,
  input  logic                          rst_n,
`ifdef MVL_ABORT_EN
  input  logic                          abort,
`endif
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  input  logic                          in_valid,
  input  logic [DATA_WIDTH-1:0]         in_data,
  output logic                          in_ready,
  output logic                          mac_clr,
  output logic [DEPTH-1:0]              a_wren,
  output logic [DATA_WIDTH-1:0]         a_data,
  output logic                          b_wren,
  output logic [DATA_WIDTH-1:0]         b_data,
  input  logic [DEPTH*3*DATA_WIDTH-1:0] res_in,
  output logic                          res_valid,
  output logic [3*DATA_WIDTH-1:0]       res_data,
  output logic [$clog2(DEPTH)-1:0]      res_idx,
  input  logic                          res_ready
);
  localparam int unsigned RES_W  = 3 * DATA_WIDTH;
  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(DEPTH * DEPTH);
  localparam int unsigned WAIT_W = 8;

  localparam logic [CNT_W-1:0]  LAST_A    = CNT_W'(DEPTH * DEPTH - 1);
  localparam logic [CNT_W-1:0]  LAST_B    = CNT_W'(DEPTH - 1);
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(COMPUTE_CYCLES - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_LOAD_A = 3'd2;
  localparam logic [2:0] S_LOAD_B = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_DRAIN  = 3'd5;

  logic [2:0]            state, state_nxt;
  logic [CNT_W-1:0]      beat_cnt, beat_nxt;
  logic [WAIT_W-1:0]     wait_cnt, wait_nxt;
  logic [RES_W-1:0]      res_buf [DEPTH];
  logic                  capture;
  logic                  accept;
  logic [IDX_W-1:0]      a_row;
  logic [DEPTH-1:0]      a_wren_nxt;
  logic [DATA_WIDTH-1:0] a_data_nxt, b_data_nxt;
  logic                  b_wren_nxt, done_nxt, clr_pulse;
  logic [IDX_W-1:0]      idx_nxt;
  logic [RES_W-1:0]      rdata_nxt;

  // Next-state, routing and drain sequencing
  always_comb begin
    state_nxt  = state;
    beat_nxt   = beat_cnt;
    wait_nxt   = wait_cnt;
    capture    = 1'b0;
    a_wren_nxt = '0;
    b_wren_nxt = 1'b0;
    a_data_nxt = a_data;
    b_data_nxt = b_data;
    idx_nxt    = res_idx;
    rdata_nxt  = res_data;
    done_nxt   = 1'b0;
    clr_pulse  = 1'b0;
    accept     = in_valid && in_ready;
    a_row      = IDX_W'(beat_cnt / CNT_W'(DEPTH));

    case (state)
      S_IDLE:  if (start) state_nxt = S_CLEAR;
      S_CLEAR: state_nxt = S_LOAD_A;
      S_LOAD_A: begin
        if (accept) begin
          a_data_nxt = in_data;
          a_wren_nxt = DEPTH'(1) << a_row;
          if (beat_cnt == LAST_A) begin
            beat_nxt  = '0;
            state_nxt = S_LOAD_B;
          end else begin
            beat_nxt = beat_cnt + CNT_W'(1);
          end
        end
      end
      S_LOAD_B: begin
        if (accept) begin
          b_data_nxt = in_data;
          b_wren_nxt = 1'b1;
          if (beat_cnt == LAST_B) begin
            beat_nxt  = '0;
            state_nxt = S_WAIT;
          end else begin
            beat_nxt = beat_cnt + CNT_W'(1);
          end
        end
      end
      S_WAIT: begin
        if (wait_cnt == LAST_WAIT) begin
          wait_nxt  = '0;
          capture   = 1'b1;
          idx_nxt   = '0;
          rdata_nxt = res_in[RES_W-1:0];
          state_nxt = S_DRAIN;
        end else begin
          wait_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      S_DRAIN: begin
        if (res_ready) begin
          if (res_idx == LAST_IDX) begin
            idx_nxt   = '0;
            rdata_nxt = '0;
            done_nxt  = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            idx_nxt   = res_idx + IDX_W'(1);
            rdata_nxt = res_buf[res_idx + IDX_W'(1)];
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase

`ifdef MVL_ABORT_EN
    // Abort wins over everything; the extra clear discards partial sums in the array
    if (abort && state != S_IDLE) begin
      state_nxt  = S_IDLE;
      beat_nxt   = '0;
      wait_nxt   = '0;
      capture    = 1'b0;
      a_wren_nxt = '0;
      b_wren_nxt = 1'b0;
      idx_nxt    = '0;
      rdata_nxt  = '0;
      done_nxt   = 1'b0;
      clr_pulse  = 1'b1;
    end
`endif
  end

  // State, counters and registered outputs; status flags are decoded from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      beat_cnt  <= '0;
      wait_cnt  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      in_ready  <= 1'b0;
      mac_clr   <= 1'b0;
      a_wren    <= '0;
      a_data    <= '0;
      b_wren    <= 1'b0;
      b_data    <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_idx   <= '0;
    end else begin
      state     <= state_nxt;
      beat_cnt  <= beat_nxt;
      wait_cnt  <= wait_nxt;
      busy      <= (state_nxt != S_IDLE);
      done      <= done_nxt;
      in_ready  <= (state_nxt == S_LOAD_A) || (state_nxt == S_LOAD_B);
      mac_clr   <= (state_nxt == S_CLEAR) || clr_pulse;
      a_wren    <= a_wren_nxt;
      a_data    <= a_data_nxt;
      b_wren    <= b_wren_nxt;
      b_data    <= b_data_nxt;
      res_valid <= (state_nxt == S_DRAIN);
      res_data  <= rdata_nxt;
      res_idx   <= idx_nxt;
    end
  end

  // Accumulator snapshot taken on the last compute-wait cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < int'(DEPTH); r++) res_buf[r] <= '0;
    end else if (capture) begin
      for (int r = 0; r < int'(DEPTH); r++) res_buf[r] <= res_in[r*RES_W +: RES_W];
    end
  end

endmodule
